// File: rtl/count_rr_arbiter.sv
// Shared count register with round-robin access arbitration among NREQ requesters.
// Each granted access runs IDLE -> XFER -> ACK and produces a one-cycle ready pulse.
module count_rr_arbiter #(
   parameter  int BITS = 16,
   parameter  int NREQ = 2,
   localparam int GW   = $clog2(NREQ)
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_we,
   input  logic [NREQ*BITS/8-1:0] req_wstrb,
   input  logic [NREQ*BITS-1:0]   req_wdata,
   input  logic                   count_en,
   output logic [NREQ-1:0]        req_ready,
   output logic [BITS-1:0]        req_rdata,
   output logic [BITS-1:0]        count,
   output logic [GW-1:0]          grant_id,
   output logic                   busy
);

   localparam int NB = BITS / 8;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   logic [1:0]      r_state;
   logic [BITS-1:0] r_count;
   logic [BITS-1:0] r_rdata;
   logic [NREQ-1:0] r_ready;
   logic [GW-1:0]   r_grant_id;
   logic [GW-1:0]   r_last_grant;

   logic            w_any_req;
   logic            w_hi_found;
   logic [GW-1:0]   w_hi_idx;
   logic [GW-1:0]   w_lo_idx;
   logic [GW-1:0]   w_winner;
   logic            w_g_valid;
   logic            w_g_we;
   logic [NB-1:0]   w_g_wstrb;
   logic [BITS-1:0] w_g_wdata;
   logic            w_commit_wr;
   logic [BITS-1:0] w_count_next;

   // Round-robin pick: lowest requester above last_grant, else lowest overall.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      w_any_req  = 1'b0;
      w_hi_found = 1'b0;
      w_hi_idx   = '0;
      w_lo_idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            w_any_req = 1'b1;
            w_lo_idx  = GW'(i);
            if (GW'(i) > r_last_grant) begin
               w_hi_found = 1'b1;
               w_hi_idx   = GW'(i);
            end
         end
      end
      w_winner = w_hi_found ? w_hi_idx : w_lo_idx;
   end

   always_comb begin
      w_g_valid = 1'b0;
      w_g_we    = 1'b0;
      w_g_wstrb = '0;
      w_g_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (GW'(i) == r_grant_id) begin
            w_g_valid = req_valid[i];
            w_g_we    = req_we[i];
            w_g_wstrb = req_wstrb[i*NB +: NB];
            w_g_wdata = req_wdata[i*BITS +: BITS];
         end
      end
   end

   // A committed write takes precedence over the free-running increment, even with no lanes set.
   always_comb begin
      w_commit_wr  = (r_state == S_XFER) && w_g_valid && w_g_we;
      w_count_next = r_count;
      if (w_commit_wr) begin
         for (int b = 0; b < NB; b++) begin
            if (w_g_wstrb[b]) w_count_next[b*8 +: 8] = w_g_wdata[b*8 +: 8];
         end
      end else if (count_en) begin
         w_count_next = r_count + BITS'(1);
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state      <= S_IDLE;
         r_count      <= '0;
         r_rdata      <= '0;
         r_ready      <= '0;
         r_grant_id   <= '0;
         r_last_grant <= GW'(NREQ - 1);
      end else begin
         r_count <= w_count_next;
         r_ready <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_grant_id   <= w_winner;
                  r_last_grant <= w_winner;
                  r_state      <= S_XFER;
               end
            end
            S_XFER: begin
               if (!w_g_valid) begin
                  r_state <= S_IDLE;
               end else begin
                  r_rdata <= r_count;
                  r_ready <= NREQ'(1) << r_grant_id;
                  r_state <= S_ACK;
               end
            end
            // Requests are not sampled here, so a requester releasing valid on ready is never re-granted.
            S_ACK:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = r_ready;
   assign req_rdata = r_rdata;
   assign count     = r_count;
   assign grant_id  = r_grant_id;
   assign busy      = (r_state != S_IDLE);

endmodule
